la_csa_accum: RTL

Sequential multi-operand accumulator built around a row of 3:2 carry-save adders. It accepts a burst of operands over a valid/ready stream and compresses each one into redundant sum/carry registers, one operand per cycle with no carry propagation. On the last operand it sequences the same CSA row to resolve the redundant pair into a binary result. It then presents the total and the operand count on a valid/ready output stream. It sits in front of multiply/dot-product datapaths that need low-cost multi-operand summation.

---
 rtl/la_csa_accum.sv | 126 ++++++++++++
 1 files changed

// File: rtl/la_csa_accum.sv
// Multi-operand accumulator: operands are folded into a redundant sum/carry pair
// by one carry-save row, which is then reused to resolve the pair into a binary total.
module la_csa_accum #(
    parameter int N    = 16,
    parameter int W    = 32,
    parameter int CW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACC, RESOLVE, OUT} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   sum_reg, sum_next;
    logic [W-1:0]   carry_reg, carry_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           zero_reg;

    logic [W-1:0]   row_c;
    logic [W-1:0]   row_s;
    logic [W-1:0]   row_cy;
    logic           accept;

    assign in_ready  = (state_reg == IDLE) || (state_reg == ACC);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == OUT);
    assign busy      = (state_reg != IDLE);
    assign out_data  = sum_reg;
    assign out_count = cnt_reg;

    // Third row input is the operand while accumulating and zero while resolving.
    assign row_c     = (state_reg == ACC) ? W'(in_data) : '0;
    assign row_cy[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_row
            if (gi < W - 1) begin : g_full
                if (PROP == "MUX") begin : g_mux
                    assign row_s[gi]    = row_c[gi] ? ~(sum_reg[gi] ^ carry_reg[gi])
                                                    :  (sum_reg[gi] ^ carry_reg[gi]);
                    assign row_cy[gi+1] = (sum_reg[gi] ^ carry_reg[gi]) ? row_c[gi] : sum_reg[gi];
                end else begin : g_xor
                    assign row_s[gi]    = sum_reg[gi] ^ carry_reg[gi] ^ row_c[gi];
                    assign row_cy[gi+1] = (sum_reg[gi] & carry_reg[gi]) |
                                          (sum_reg[gi] & row_c[gi]) |
                                          (carry_reg[gi] & row_c[gi]);
                end
            end else begin : g_msb
                // Carry out of the top bit falls off: arithmetic is modulo 2^W.
                assign row_s[gi] = sum_reg[gi] ^ carry_reg[gi] ^ row_c[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    sum_next   = W'(in_data);
                    carry_next = '0;
                    cnt_next   = CW'(1);
                    state_next = in_last ? RESOLVE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    sum_next   = row_s;
                    carry_next = row_cy;
                    cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + CW'(1);
                    state_next = in_last ? RESOLVE : ACC;
                end
            end
            RESOLVE: begin
                // The wide zero test is taken from a register, which adds one check cycle.
                if (zero_reg) begin
                    state_next = OUT;
                end else if (carry_reg != '0) begin
                    sum_next   = row_s;
                    carry_next = row_cy;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                    sum_next   = '0;
                    carry_next = '0;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sum_reg   <= '0;
            carry_reg <= '0;
            cnt_reg   <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            zero_reg  <= (state_reg == RESOLVE) && (carry_reg == '0);
        end
    end

endmodule
